// File: rtl/mandelbrot_pkg.sv
// Shared types and fixed-point constants for the Mandelbrot frame sequencer.
// Coordinates are signed Q10.22; defaults frame the classic [-2,2) x [-1.5,1.5) view.
package mandelbrot_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    PLOT,
    DONE
  } state_t;

  typedef logic signed [31:0] fixed_t;

  localparam int     FRAC_BITS = 22;
  localparam fixed_t FX_ONE    = fixed_t'(1 << FRAC_BITS);

  // 0.0125 per pixel is FX_ONE/80, truncated to 32'h0000_CCCC
  localparam fixed_t DEF_X0 = fixed_t'(-2 * FX_ONE);
  localparam fixed_t DEF_Y0 = fixed_t'(-(3 * FX_ONE) / 2);
  localparam fixed_t DEF_DX = fixed_t'(FX_ONE / 80);
  localparam fixed_t DEF_DY = fixed_t'(FX_ONE / 80);

endpackage

// File: rtl/mandelbrot_coord_gen.sv
// Raster x/y counters with incrementally accumulated complex coordinate.
// load restarts the frame at the origin; advance steps one pixel in raster order.
module mandelbrot_coord_gen
  import mandelbrot_pkg::*;
#(
  parameter int     WIDTH  = 320,
  parameter int     HEIGHT = 240,
  parameter fixed_t X0     = DEF_X0,
  parameter fixed_t Y0     = DEF_Y0,
  parameter fixed_t DX     = DEF_DX,
  parameter fixed_t DY     = DEF_DY
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        advance,
  output logic [8:0]  x,
  output logic [7:0]  y,
  output logic [31:0] c_re,
  output logic [31:0] c_im,
  output logic        last_pixel
);

  logic [8:0] x_reg;
  logic [7:0] y_reg;
  fixed_t     c_re_reg;
  fixed_t     c_im_reg;
  logic       x_last;
  logic       y_last;

  assign x_last = (x_reg == 9'(WIDTH - 1));
  assign y_last = (y_reg == 8'(HEIGHT - 1));

  always_ff @(posedge clk) begin
    if (rst || load) begin
      x_reg    <= '0;
      y_reg    <= '0;
      c_re_reg <= X0;
      c_im_reg <= Y0;
    end else if (advance) begin
      if (!x_last) begin
        x_reg    <= x_reg + 9'd1;
        c_re_reg <= c_re_reg + DX;
      end else begin
        // Row wrap reloads c_re exactly, so truncation error never accumulates across rows
        x_reg    <= '0;
        c_re_reg <= X0;
        if (!y_last) begin
          y_reg    <= y_reg + 8'd1;
          c_im_reg <= c_im_reg + DY;
        end
      end
    end
  end

  assign x          = x_reg;
  assign y          = y_reg;
  assign c_re       = c_re_reg;
  assign c_im       = c_im_reg;
  assign last_pixel = x_last && y_last;

endmodule

// File: rtl/mandelbrot_sched.sv
// Frame sequencer: issues one pixel at a time to the iteration core and plots its colour.
// Optional cycle counter output perf_cycles is enabled by MANDELBROT_SCHED_PERF_EN.
module mandelbrot_sched
  import mandelbrot_pkg::*;
#(
  parameter int     WIDTH  = 320,
  parameter int     HEIGHT = 240,
  parameter int     ITER_W = 8,
  parameter fixed_t X0     = DEF_X0,
  parameter fixed_t Y0     = DEF_Y0,
  parameter fixed_t DX     = DEF_DX,
  parameter fixed_t DY     = DEF_DY
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              done,
  output logic              core_req,
  input  logic              core_ready,
  output logic [31:0]       core_c_re,
  output logic [31:0]       core_c_im,
  input  logic              core_rsp_valid,
  input  logic [ITER_W-1:0] core_iter,
  input  logic              core_escaped,
  output logic [8:0]        vga_x,
  output logic [7:0]        vga_y,
  output logic [2:0]        vga_colour,
  output logic              vga_plot
`ifdef MANDELBROT_SCHED_PERF_EN
  ,
  output logic [31:0]       perf_cycles
`endif
);

  state_t     state_reg;
  state_t     state_next;
  logic       load;
  logic       advance;
  logic       capture;
  logic       last_pixel;
  logic [8:0] x_cur;
  logic [7:0] y_cur;
  logic [8:0] vga_x_reg;
  logic [7:0] vga_y_reg;
  logic [2:0] vga_colour_reg;
  logic       unused_iter_hi;

  // Only the low three iteration bits select a palette entry
  assign unused_iter_hi = ^core_iter[ITER_W-1:3];

  mandelbrot_coord_gen #(
    .WIDTH (WIDTH),
    .HEIGHT(HEIGHT),
    .X0    (X0),
    .Y0    (Y0),
    .DX    (DX),
    .DY    (DY)
  ) u_coord (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .advance   (advance),
    .x         (x_cur),
    .y         (y_cur),
    .c_re      (core_c_re),
    .c_im      (core_c_im),
    .last_pixel(last_pixel)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    load       = 1'b0;
    advance    = 1'b0;
    capture    = 1'b0;
    core_req   = 1'b0;
    vga_plot   = 1'b0;
    done       = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          load       = 1'b1;
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        core_req = 1'b1;
        if (core_ready) begin
          state_next = WAIT;
        end
      end
      WAIT: begin
        if (core_rsp_valid) begin
          capture    = 1'b1;
          state_next = PLOT;
        end
      end
      PLOT: begin
        vga_plot   = 1'b1;
        advance    = 1'b1;
        state_next = last_pixel ? DONE : ISSUE;
      end
      DONE: begin
        done = 1'b1;
        if (!start) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vga_x_reg      <= '0;
      vga_y_reg      <= '0;
      vga_colour_reg <= '0;
    end else if (capture) begin
      vga_x_reg      <= x_cur;
      vga_y_reg      <= y_cur;
      vga_colour_reg <= core_escaped ? core_iter[2:0] : 3'b000;
    end
  end

  assign vga_x      = vga_x_reg;
  assign vga_y      = vga_y_reg;
  assign vga_colour = vga_colour_reg;

`ifdef MANDELBROT_SCHED_PERF_EN
  logic [31:0] perf_reg;
  logic        busy;

  assign busy = (state_reg == ISSUE) || (state_reg == WAIT) || (state_reg == PLOT);

  always_ff @(posedge clk) begin
    if (rst || load) begin
      perf_reg <= '0;
    end else if (busy && (perf_reg != 32'hFFFF_FFFF)) begin
      perf_reg <= perf_reg + 32'd1;
    end
  end

  assign perf_cycles = perf_reg;
`endif

endmodule

// File: tb/tb_mandelbrot_sched.sv
// Self-checking bench for mandelbrot_sched, run on a 320x3 frame to bound simulation time.
// Expected coordinates are computed directly as X0 + x*DX / Y0 + y*DY.
module tb_mandelbrot_sched;

  localparam int W = 320;
  localparam int H = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        done;
  logic        core_req;
  logic        core_ready;
  logic [31:0] core_c_re;
  logic [31:0] core_c_im;
  logic        core_rsp_valid;
  logic [7:0]  core_iter;
  logic        core_escaped;
  logic [8:0]  vga_x;
  logic [7:0]  vga_y;
  logic [2:0]  vga_colour;
  logic        vga_plot;
`ifdef MANDELBROT_SCHED_PERF_EN
  logic [31:0] perf_cycles;
`endif

  int vectors    = 0;
  int miscompares = 0;
  int plot_count = 0;

  always #5 clk = ~clk;

  mandelbrot_sched #(.WIDTH(W), .HEIGHT(H)) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .done          (done),
    .core_req      (core_req),
    .core_ready    (core_ready),
    .core_c_re     (core_c_re),
    .core_c_im     (core_c_im),
    .core_rsp_valid(core_rsp_valid),
    .core_iter     (core_iter),
    .core_escaped  (core_escaped),
    .vga_x         (vga_x),
    .vga_y         (vga_y),
    .vga_colour    (vga_colour),
    .vga_plot      (vga_plot)
`ifdef MANDELBROT_SCHED_PERF_EN
    ,
    .perf_cycles   (perf_cycles)
`endif
  );

  always @(negedge clk) begin
    if (vga_plot === 1'b1) plot_count++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_re(input int x);
    return 32'hFF80_0000 + 32'(x) * 32'h0000_CCCC;
  endfunction

  function automatic logic [31:0] model_im(input int y);
    return 32'hFFA0_0000 + 32'(y) * 32'h0000_CCCC;
  endfunction

  function automatic logic [2:0] model_colour(input logic [7:0] iter, input logic esc);
    return esc ? 3'(iter % 8) : 3'd0;
  endfunction

  // Wait (bounded) for the DUT to request a pixel and check the offered coordinate
  task automatic wait_issue(input int ex, input int ey);
    int n;
    n = 0;
    while (core_req !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    check("issue_seen", 32'(core_req), 32'd1);
    check("c_re", core_c_re, model_re(ex));
    check("c_im", core_c_im, model_im(ey));
  endtask

  task automatic serve_pixel(input int ex, input int ey, input int stall, input int lat,
                             input logic [7:0] iter, input logic esc, input logic spurious);
    wait_issue(ex, ey);
    repeat (stall) begin
      tick();
      check("req_hold", 32'(core_req), 32'd1);
      check("c_re_hold", core_c_re, model_re(ex));
    end
    core_ready     = 1'b1;
    core_rsp_valid = spurious;
    core_iter      = 8'h07;
    core_escaped   = 1'b1;
    tick();
    core_ready     = 1'b0;
    core_rsp_valid = 1'b0;
    check("req_drop", 32'(core_req), 32'd0);
    check("no_plot_after_xfer", 32'(vga_plot), 32'd0);
    repeat (lat) begin
      tick();
      check("no_early_plot", 32'(vga_plot), 32'd0);
    end
    core_rsp_valid = 1'b1;
    core_iter      = iter;
    core_escaped   = esc;
    tick();
    core_rsp_valid = 1'b0;
    core_iter      = 8'($urandom);
    core_escaped   = 1'($urandom);
    check("plot", 32'(vga_plot), 32'd1);
    check("vga_x", 32'(vga_x), 32'(ex));
    check("vga_y", 32'(vga_y), 32'(ey));
    check("colour", 32'(vga_colour), 32'(model_colour(iter, esc)));
    $display("pixel (%0d,%0d) iter=%0d esc=%0d colour=%0d", ex, ey, iter, esc, vga_colour);
    tick();
    check("plot_one_cycle", 32'(vga_plot), 32'd0);
  endtask

  initial begin
    int base;
    logic [7:0] it;
    rst = 1'b1; start = 1'b0; core_ready = 1'b0; core_rsp_valid = 1'b0;
    core_iter = '0; core_escaped = 1'b0;
    tick(); tick();
    rst = 1'b0;

    // Reset and idle
    repeat (100) begin
      check("idle_done", 32'(done), 32'd0);
      check("idle_req", 32'(core_req), 32'd0);
      check("idle_plot", 32'(vga_plot), 32'd0);
      check("idle_xyc", {20'd0, vga_colour, vga_y[0], vga_x[0], 7'd0} | 32'(vga_x) | 32'(vga_y), 32'd0);
      check("idle_re", core_c_re, 32'hFF80_0000);
      check("idle_im", core_c_im, 32'hFFA0_0000);
      tick();
    end

    // Frame 1: zero-latency core, directed first pixels, start held through done
    base  = plot_count;
    start = 1'b1;
    for (int py = 0; py < H; py++) begin
      for (int px = 0; px < W; px++) begin
        if (py == 0 && px == 0)      serve_pixel(px, py, 0, 0, 8'd5, 1'b1, 1'b0);
        else if (py == 0 && px == 1) serve_pixel(px, py, 0, 0, 8'd16, 1'b0, 1'b0);
        else                         serve_pixel(px, py, 0, 0, 8'($urandom), 1'($urandom), 1'b0);
      end
    end
    check("f1_done", 32'(done), 32'd1);
    check("f1_plots", 32'(plot_count - base), 32'(W * H));
`ifdef MANDELBROT_SCHED_PERF_EN
    check("perf_cycles", perf_cycles, 32'(3 * W * H));
`endif
    repeat (5) begin
      tick();
      check("done_hold", 32'(done), 32'd1);
      check("done_no_req", 32'(core_req), 32'd0);
`ifdef MANDELBROT_SCHED_PERF_EN
      check("perf_frozen", perf_cycles, 32'(3 * W * H));
`endif
    end
    start = 1'b0;
    tick();
    check("done_clear", 32'(done), 32'd0);
    repeat (5) begin
      tick();
      check("idle_after_done", 32'(core_req), 32'd0);
    end

    // Frame 2: random stalls/latency, start dropped mid-frame
    base  = plot_count;
    start = 1'b1;
    for (int py = 0; py < H; py++) begin
      for (int px = 0; px < W; px++) begin
        it = 8'($urandom);
        serve_pixel(px, py, $urandom_range(0, 5), $urandom_range(0, 19), it, 1'($urandom),
                    1'($urandom));
        start = 1'b0;
      end
    end
    check("f2_done", 32'(done), 32'd1);
    check("f2_plots", 32'(plot_count - base), 32'(W * H));
    tick();
    check("f2_done_clear", 32'(done), 32'd0);

    // Frame 3: reset while pixel 500 is in flight
    start = 1'b1;
    for (int p = 0; p < 500; p++) begin
      serve_pixel(p % W, p / W, $urandom_range(0, 5), $urandom_range(0, 19), 8'($urandom),
                  1'($urandom), 1'b0);
    end
    wait_issue(500 % W, 500 / W);
    core_ready = 1'b1;
    tick();
    core_ready = 1'b0;
    rst = 1'b1;
    tick();
    rst   = 1'b0;
    start = 1'b0;
    base  = plot_count;
    core_rsp_valid = 1'b1;
    core_iter = 8'd3; core_escaped = 1'b1;
    tick();
    core_rsp_valid = 1'b0;
    repeat (3) begin
      check("rst_no_plot", 32'(vga_plot), 32'd0);
      check("rst_no_req", 32'(core_req), 32'd0);
      check("rst_colour", 32'(vga_colour), 32'd0);
      check("rst_re", core_c_re, 32'hFF80_0000);
      tick();
    end
    check("rst_plots", 32'(plot_count - base), 32'd0);
    start = 1'b1;
    serve_pixel(0, 0, 1, 2, 8'd6, 1'b1, 1'b0);
    serve_pixel(1, 0, 0, 0, 8'd9, 1'b1, 1'b0);
    start = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mandelbrot_sched.md
Name: mandelbrot_sched

Overview:
- Frame-level sequencer for the Mandelbrot renderer.
- Raster-walks the 320x240 VGA frame and derives each pixel's complex coordinate c = (c_re, c_im) in Q10.22 by incremental addition.
- Hands each pixel to the per-pixel iteration core over a valid/ready handshake, waits for its result, maps the result to a colour and emits one vga_plot pulse per pixel.
- Sits between the top-level start/done control and the iteration datapath.

Parameters:
- WIDTH, 320, pixels per row (vga_x range 0..WIDTH-1).
- HEIGHT, 240, rows per frame (vga_y range 0..HEIGHT-1).
- ITER_W, 8, width of the iteration count returned by the core.
- X0, 32'hFF80_0000, c_re at x=0 (-2.0, Q10.22).
- Y0, 32'hFFA0_0000, c_im at y=0 (-1.5, Q10.22).
- DX, 32'h0000_CCCC, c_re step per pixel (0.0125, truncated).
- DY, 32'h0000_CCCC, c_im step per row (0.0125, truncated).

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  level request to render one frame.
- done  out  1  high while the frame is complete.
- core_req  out  1  pixel valid to the iteration core.
- core_ready  in  1  core accepts a pixel.
- core_c_re  out  32  signed Q10.22 real part.
- core_c_im  out  32  signed Q10.22 imaginary part.
- core_rsp_valid  in  1  one-cycle result strobe from the core.
- core_iter  in  ITER_W  iterations executed.
- core_escaped  in  1  |z|^2 exceeded the bound before max iterations.
- vga_x  out  9  plot column.
- vga_y  out  8  plot row.
- vga_colour  out  3  plot colour.
- vga_plot  out  1  one-cycle plot strobe.

Behaviour:
- Reset: synchronous on rst=1. State goes to IDLE. done, core_req and vga_plot are 0. vga_x, vga_y and vga_colour are 0. core_c_re=X0, core_c_im=Y0. x and y counters are 0.
- IDLE: when start=1, load x=0, y=0, c_re=X0, c_im=Y0, then go to ISSUE.
- ISSUE:
  - core_req=1. c_re and c_im are held stable until the transfer.
  - Transfer occurs on the cycle where core_req && core_ready; go to WAIT.
  - core_req may not drop before the transfer.
- WAIT:
  - core_req=0.
  - On core_rsp_valid: register vga_colour = core_escaped ? core_iter[2:0] : 3'b000. Register vga_x=x, vga_y=y. Go to PLOT.
  - core_rsp_valid outside WAIT is ignored.
- PLOT:
  - vga_plot=1 for exactly this cycle.
  - Advance the coordinates:
    - If x<WIDTH-1: x+=1, c_re+=DX.
    - Otherwise x=0, c_re=X0, and then if y<HEIGHT-1: y+=1, c_im+=DY.
  - If x=WIDTH-1 and y=HEIGHT-1, go to DONE; otherwise go to ISSUE.
- DONE:
  - done=1.
  - While start=1, stay in DONE (no auto-restart).
  - When start=0, drop done and return to IDLE.
- Arithmetic: 32-bit two's-complement add with wrap; no saturation. c_re/c_im are never recomputed by multiplication.
- Throughput: at most one pixel in flight. Minimum 3 cycles per pixel (ISSUE/WAIT/PLOT), with zero core latency.
- start deasserted mid-frame: has no effect; the frame completes.
- rst mid-frame: aborts immediately to reset values. An in-flight core result is discarded; the core is expected to be reset alongside.
- Simultaneous core_ready and core_rsp_valid in ISSUE: the transfer is taken and rsp_valid is ignored.

Optional Feature:
- Macro: MANDELBROT_SCHED_PERF_EN.
- Defined:
  - Adds output perf_cycles (32-bit).
  - Cleared on the IDLE->ISSUE transition and incremented every cycle in ISSUE, WAIT and PLOT.
  - Frozen in DONE, saturating at 32'hFFFF_FFFF.
  - Reset value is 0.
- Undefined: the port and counter are absent; behaviour is otherwise identical.

Decomposition:
- Package mandelbrot_pkg holds:
  - the state enum (IDLE, ISSUE, WAIT, PLOT, DONE);
  - typedef fixed_t (logic signed [31:0]);
  - constants FRAC_BITS=22, FX_ONE=32'h0040_0000;
  - the default X0/Y0/DX/DY values.
- One sub-module, mandelbrot_coord_gen, holds the x/y counters and c_re/c_im accumulators. It has load and advance inputs and a last_pixel output.
- The FSM and colour mapping stay in mandelbrot_sched.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, start=0 -> all outputs 0, core_c_re=32'hFF80_0000, done=0 for 100 cycles.
- Single-pixel sequence: core_ready=1, response 1 cycle after transfer with iter=5, escaped=1 -> first vga_plot shows x=0, y=0, colour=3'b101; second pixel issues with core_c_re=32'hFF80_CCCC.
- Row wrap: run to x=319, y=0 -> next issue has core_c_re=32'hFF80_0000, core_c_im=32'hFFA0_CCCC; the plot after that shows x=0, y=1.
- Non-escaped colour: escaped=0, iter=16 -> vga_colour=3'b000.
- Full frame with random core_ready stalls (0-5 cycles) and response latency (1-20 cycles):
  - exactly 76800 vga_plot pulses, each (x,y) exactly once;
  - done rises after the plot at (319,239);
  - done stays high while start=1 and clears one cycle after start=0.
- Reset mid-frame: assert rst at pixel 1000 while in WAIT, then pulse core_rsp_valid -> no vga_plot, state IDLE; a restarted frame begins at x=0, y=0.
- Perf counter (MANDELBROT_SCHED_PERF_EN defined): with zero-latency core and core_ready=1 -> perf_cycles=230400 at done.
